int_controller: RTL and testbench

- Parametrised interrupt controller; successor to the fixed 7-input interrupt mask inside the MCU resources block.
- Accepts N_INTS external interrupt requests; each source is synchronised and configurable as edge or level.
- Each source has an individual mask and a 2-level priority assignment. Drives the core's INT0 (low priority) and INT1 (high priority).
- Provides a CPU register interface with a vector/acknowledge read.

---
 rtl/int_controller.sv | 133 +++++++++++++
 tb/tb_int_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Interrupt controller: per-source synchroniser, edge/level capture, mask and
// two-level priority onto INT0/INT1, plus a register port with a vector/ack read.
module int_controller #(
  parameter int N_INTS      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [N_INTS-1:0] INTS,
  input  logic              CS,
  input  logic              RD,
  input  logic              WR,
  input  logic [2:0]        REG_ADDR,
  input  logic [15:0]       WDATA,
  output logic [15:0]       RDATA,
  output logic              INT0,
  output logic              INT1
);

  localparam logic [2:0] ADDR_ENABLE  = 3'd0;
  localparam logic [2:0] ADDR_MODE    = 3'd1;
  localparam logic [2:0] ADDR_PRIO    = 3'd2;
  localparam logic [2:0] ADDR_PENDING = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  // Stage 0 occupies the low N_INTS bits; the last stage is the top slice.
  logic [SYNC_STAGES*N_INTS-1:0] sync_reg;
  logic [N_INTS-1:0] prev_reg;
  logic [N_INTS-1:0] enable_reg;
  logic [N_INTS-1:0] mode_reg;
  logic [N_INTS-1:0] prio_reg;
  logic [N_INTS-1:0] pending_reg;
  logic [N_INTS-1:0] pending_next;

  logic [N_INTS-1:0] sync_s;
  logic [N_INTS-1:0] edge_set;
  logic [N_INTS-1:0] w1c;
  logic [N_INTS-1:0] vec_clr;
  logic [N_INTS-1:0] act;
  logic [N_INTS-1:0] act_hi;
  logic [N_INTS-1:0] act_lo;

  logic        wr_en;
  logic        rd_en;
  logic        vec_rd;
  logic        win_any;
  logic        win_hi;
  logic [3:0]  win_idx;
  logic [15:0] vector;
  logic [15:0] rdata_next;
  logic        unused_wdata;

  assign sync_s       = sync_reg[SYNC_STAGES*N_INTS-1 -: N_INTS];
  assign edge_set     = sync_s & ~prev_reg;
  assign wr_en        = CS & WR;
  assign rd_en        = CS & RD;
  assign vec_rd       = rd_en && (REG_ADDR == ADDR_VECTOR);
  assign act          = pending_reg & enable_reg;
  assign act_hi       = act & prio_reg;
  assign act_lo       = act & ~prio_reg;
  assign unused_wdata = ^WDATA;

  // Winner: lowest-numbered high-priority source, else lowest-numbered low one.
  always_comb begin
    win_any = |act;
    win_hi  = |act_hi;
    win_idx = 4'd0;
    for (int i = N_INTS - 1; i >= 0; i--) begin
      if (win_hi ? act_hi[i] : act_lo[i]) begin
        win_idx = 4'(i);
      end
    end
    vector = {win_any, win_hi, 10'd0, win_idx};
  end

  // Edge-mode bits: a new edge beats any clear in the same cycle.
  // Level-mode bits simply mirror the synchronised input.
  generate
    for (genvar gi = 0; gi < N_INTS; gi++) begin : g_src
      assign w1c[gi]     = wr_en && (REG_ADDR == ADDR_PENDING) && WDATA[gi];
      assign vec_clr[gi] = vec_rd && win_any && (win_idx == 4'(gi));
      assign pending_next[gi] = mode_reg[gi]
          ? (edge_set[gi] | (pending_reg[gi] & ~(w1c[gi] | vec_clr[gi])))
          : sync_s[gi];
    end
  endgenerate

  always_comb begin
    rdata_next = 16'd0;
    case (REG_ADDR)
      ADDR_ENABLE:  rdata_next = 16'(enable_reg);
      ADDR_MODE:    rdata_next = 16'(mode_reg);
      ADDR_PRIO:    rdata_next = 16'(prio_reg);
      ADDR_PENDING: rdata_next = 16'(pending_reg);
      ADDR_VECTOR:  rdata_next = vector;
      ADDR_RAW:     rdata_next = 16'(sync_s);
      default:      rdata_next = 16'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_reg    <= '0;
      prev_reg    <= '0;
      enable_reg  <= '0;
      mode_reg    <= '0;
      prio_reg    <= '0;
      pending_reg <= '0;
      RDATA       <= 16'd0;
      INT0        <= 1'b0;
      INT1        <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[(SYNC_STAGES-1)*N_INTS-1:0], INTS};
      prev_reg    <= sync_s;
      pending_reg <= pending_next;
      INT1        <= |act_hi;
      INT0        <= |act_lo;
      if (wr_en) begin
        case (REG_ADDR)
          ADDR_ENABLE: enable_reg <= WDATA[N_INTS-1:0];
          ADDR_MODE:   mode_reg   <= WDATA[N_INTS-1:0];
          ADDR_PRIO:   prio_reg   <= WDATA[N_INTS-1:0];
          default:     ;
        endcase
      end
      if (rd_en) begin
        RDATA <= rdata_next;
      end
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: three instances (default, 16/3, 1/2)
// share the register bus; expectations are queued and checked by a monitor.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs, rd_s, wr_s;
  logic [2:0]  reg_addr;
  logic [15:0] wdata;
  logic [6:0]  ints7;
  logic [15:0] ints16;
  logic [0:0]  ints1;
  logic [15:0] rdata7, rdata16, rdata1;
  logic        int0_7, int1_7, int0_16, int1_16, int0_1, int1_1;
  logic        obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } rd_item_t;

  typedef struct {
    int          sel;
    logic [1:0]  exp;
    string       name;
  } int_item_t;

  rd_item_t  rd_q[$];
  int_item_t ob_q[$];

  always #5 clk = ~clk;

  int_controller #(.N_INTS(7), .SYNC_STAGES(2)) dut7 (
    .CLK(clk), .RESETN(resetn), .INTS(ints7), .CS(cs), .RD(rd_s), .WR(wr_s),
    .REG_ADDR(reg_addr), .WDATA(wdata), .RDATA(rdata7), .INT0(int0_7), .INT1(int1_7)
  );

  int_controller #(.N_INTS(16), .SYNC_STAGES(3)) dut16 (
    .CLK(clk), .RESETN(resetn), .INTS(ints16), .CS(cs), .RD(rd_s), .WR(wr_s),
    .REG_ADDR(reg_addr), .WDATA(wdata), .RDATA(rdata16), .INT0(int0_16), .INT1(int1_16)
  );

  int_controller #(.N_INTS(1), .SYNC_STAGES(2)) dut1 (
    .CLK(clk), .RESETN(resetn), .INTS(ints1), .CS(cs), .RD(rd_s), .WR(wr_s),
    .REG_ADDR(reg_addr), .WDATA(wdata), .RDATA(rdata1), .INT0(int0_1), .INT1(int1_1)
  );

  function automatic logic [15:0] get_rdata(input int sel);
    case (sel)
      0:       return rdata7;
      1:       return rdata16;
      default: return rdata1;
    endcase
  endfunction

  function automatic logic [1:0] get_ints(input int sel);
    case (sel)
      0:       return {int1_7, int0_7};
      1:       return {int1_16, int0_16};
      default: return {int1_1, int0_1};
    endcase
  endfunction

  // Monitor: a read seen at an edge presents RDATA after it; obs requests an INT sample.
  initial begin
    logic      rd_hit, ob_hit;
    rd_item_t  r;
    int_item_t o;
    logic [15:0] got_d;
    logic [1:0]  got_i;
    forever begin
      @(posedge clk);
      rd_hit = cs && rd_s;
      ob_hit = obs;
      @(negedge clk);
      if (rd_hit) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got read with empty queue, required queued expectation");
        end else begin
          r = rd_q.pop_front();
          got_d = get_rdata(r.sel);
          if (got_d !== r.exp) begin
            errors++;
            $display("FAIL %s: rdata got %h required %h", r.name, got_d, r.exp);
          end else begin
            $display("ok   %s: rdata %h", r.name, got_d);
          end
        end
      end
      if (ob_hit) begin
        checks++;
        if (ob_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_obs: got sample request with empty queue");
        end else begin
          o = ob_q.pop_front();
          got_i = get_ints(o.sel);
          if (got_i !== o.exp) begin
            errors++;
            $display("FAIL %s: {INT1,INT0} got %b required %b", o.name, got_i, o.exp);
          end else begin
            $display("ok   %s: {INT1,INT0} %b", o.name, got_i);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cs   = 1'b0;
    rd_s = 1'b0;
    wr_s = 1'b0;
    obs  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; wr_s = 1'b1; reg_addr = a; wdata = d;
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input logic [15:0] e, input string n);
    rd_item_t it;
    it.sel = sel; it.exp = e; it.name = n;
    rd_q.push_back(it);
    cs = 1'b1; rd_s = 1'b1; reg_addr = a;
  endtask

  task automatic chk_int(input int sel, input logic e1, input logic e0, input string n);
    int_item_t it;
    it.sel = sel; it.exp = {e1, e0}; it.name = n;
    ob_q.push_back(it);
    obs = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; cs = 1'b0; rd_s = 1'b0; wr_s = 1'b0; obs = 1'b0;
    reg_addr = 3'd0; wdata = 16'd0;
    ints7 = '0; ints16 = '0; ints1 = '0;

    // Reset held: inputs toggling, everything stays zero
    tick(); tick();
    ints7 = '1; ints16 = '1; ints1 = '1;
    rd(0, 3'd3, 16'h0000, "rst_rd7"); chk_int(0, 1'b0, 1'b0, "rst_int7"); tick();
    ints7 = '0; ints16 = '0; ints1 = '0;
    rd(1, 3'd5, 16'h0000, "rst_rd16"); chk_int(1, 1'b0, 1'b0, "rst_int16"); tick();
    ints7 = '1;
    rd(2, 3'd0, 16'h0000, "rst_rd1"); chk_int(2, 1'b0, 1'b0, "rst_int1"); tick();
    ints7 = '0; tick();
    resetn = 1'b1; tick(); tick(); tick();
    for (int a = 0; a < 8; a++) begin
      rd(0, 3'(a), 16'h0000, $sformatf("rst_addr%0d", a)); tick();
    end

    // Edge latency on source 0
    wr(3'd0, 16'h0001); tick();
    wr(3'd1, 16'h0001); tick();
    wr(3'd2, 16'h0000); tick();
    ints7 = 7'h01; tick();
    ints7 = 7'h00; tick();
    chk_int(0, 1'b0, 1'b0, "lat_int_k2"); tick();
    rd(0, 3'd3, 16'h0001, "lat_pend"); chk_int(0, 1'b0, 1'b1, "lat_int_k3"); tick();
    rd(0, 3'd4, 16'h8000, "lat_vec"); chk_int(0, 1'b0, 1'b1, "lat_int_k4"); tick();
    rd(0, 3'd3, 16'h0000, "lat_pend_clr"); chk_int(0, 1'b0, 1'b0, "lat_int_k5"); tick();

    // Priority: sources 1 (INT0 group) and 5 (INT1 group) together
    wr(3'd0, 16'h007F); tick();
    wr(3'd1, 16'h007F); tick();
    wr(3'd2, 16'h0020); tick();
    ints7 = 7'h22; tick();
    ints7 = 7'h00; tick(); tick();
    chk_int(0, 1'b1, 1'b1, "pri_both"); tick();
    rd(0, 3'd4, 16'hC005, "pri_vec1"); tick();
    rd(0, 3'd4, 16'h8001, "pri_vec2"); chk_int(0, 1'b0, 1'b1, "pri_int1_drop"); tick();
    rd(0, 3'd4, 16'h0000, "pri_vec3"); chk_int(0, 1'b0, 1'b0, "pri_int0_drop"); tick();

    // Level mode on source 2
    wr(3'd1, 16'h0000); tick();
    wr(3'd0, 16'h0004); tick();
    ints7 = 7'h04; tick(); tick(); tick();
    rd(0, 3'd4, 16'h8002, "lvl_vec1"); chk_int(0, 1'b0, 1'b1, "lvl_int"); tick();
    rd(0, 3'd4, 16'h8002, "lvl_vec2"); tick();
    wr(3'd3, 16'h0004); tick();
    rd(0, 3'd3, 16'h0004, "lvl_w1c"); chk_int(0, 1'b0, 1'b1, "lvl_int_w1c"); tick();
    ints7 = 7'h00; tick(); tick();
    chk_int(0, 1'b0, 1'b1, "lvl_hold"); tick();
    chk_int(0, 1'b0, 1'b0, "lvl_drop"); tick();

    // Mask, then W1C colliding with a fresh edge on source 3
    wr(3'd0, 16'h0000); tick();
    wr(3'd1, 16'h0008); tick();
    ints7 = 7'h08; tick();
    ints7 = 7'h00; tick(); tick();
    rd(0, 3'd3, 16'h0008, "msk_pend"); chk_int(0, 1'b0, 1'b0, "msk_int_off"); tick();
    wr(3'd0, 16'h0008); tick();
    chk_int(0, 1'b0, 1'b1, "msk_int_on"); tick();
    ints7 = 7'h08; tick();
    ints7 = 7'h00; tick();
    wr(3'd3, 16'h0008); tick();
    rd(0, 3'd3, 16'h0008, "col_pend"); tick();
    wr(3'd3, 16'h0008); tick();
    rd(0, 3'd3, 16'h0000, "w1c_pend"); chk_int(0, 1'b0, 1'b0, "w1c_int"); tick();

    resetn = 1'b0; tick();
    resetn = 1'b1; tick(); tick();

    // N_INTS=16, SYNC_STAGES=3: source 15
    wr(3'd0, 16'hFFFF); tick();
    wr(3'd1, 16'hFFFF); tick();
    wr(3'd2, 16'h0000); tick();
    ints16 = 16'h8000; tick();
    ints16 = 16'h0000; tick(); tick();
    rd(1, 3'd3, 16'h0000, "p16_pend_k2"); tick();
    rd(1, 3'd3, 16'h8000, "p16_pend_k3"); chk_int(1, 1'b0, 1'b1, "p16_int0"); tick();
    rd(1, 3'd4, 16'h800F, "p16_vec"); tick();
    rd(1, 3'd3, 16'h0000, "p16_clr"); tick();

    // N_INTS=1: upper bits always read 0
    wr(3'd0, 16'hFFFF); tick();
    wr(3'd1, 16'hFFFF); tick();
    wr(3'd2, 16'hFFFF); tick();
    ints1 = 1'b1; tick(); tick(); tick();
    rd(2, 3'd0, 16'h0001, "n1_en"); chk_int(2, 1'b1, 1'b0, "n1_int1"); tick();
    rd(2, 3'd1, 16'h0001, "n1_mode"); tick();
    rd(2, 3'd2, 16'h0001, "n1_prio"); tick();
    rd(2, 3'd3, 16'h0001, "n1_pend"); tick();
    rd(2, 3'd5, 16'h0001, "n1_raw"); tick();
    rd(2, 3'd4, 16'hC000, "n1_vec"); tick();
    rd(2, 3'd3, 16'h0000, "n1_pend_clr"); tick();
    ints1 = 1'b0; tick(); tick(); tick();

    checks++;
    if (rd_q.size() != 0 || ob_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d reads and %0d samples left, required 0 and 0",
               rd_q.size(), ob_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
